// File: rtl/pll_reset_seq_if.sv
// Lock input, reset output, clock enables and debug state of the PLL reset sequencer.
// The sequencer drives this bundle through the master modport.
interface pll_reset_seq_if;
    logic       pll_locked;
    logic       core_reset_n;
    logic       ce_cpu;
    logic       ce_snd;
    logic [1:0] seq_state;

    modport master (
        input  pll_locked,
        output core_reset_n,
        output ce_cpu,
        output ce_snd,
        output seq_state
    );

    modport slave (
        output pll_locked,
        input  core_reset_n,
        input  ce_cpu,
        input  ce_snd,
        input  seq_state
    );
endinterface

// File: rtl/pll_reset_seq.sv
// PLL lock qualifier, core reset release sequencer and fractional clock-enable generator.
// Define PLL_SEQ_SND_CE_EN to build the sound enable accumulator; otherwise ce_snd is tied low.
module pll_reset_seq #(
    parameter int LOCK_CYCLES = 4096,
    parameter int RESET_TAIL  = 64,
    parameter int ACC_W       = 16,
    parameter int CPU_INC     = 4194,
    parameter int SND_INC     = 1222
) (
    input  logic            clk_sys,
    input  logic            rst_n,
    pll_reset_seq_if.master seq_io
);
    localparam int CNT_MAX = (LOCK_CYCLES > RESET_TAIL) ? LOCK_CYCLES : RESET_TAIL;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(RESET_TAIL - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        PRE_RUN   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_q, lock_s_q;
    logic             core_reset_n_q;
    logic             acc_en;
    logic [ACC_W-1:0] acc_cpu_q, acc_cpu_d;
    logic             ce_cpu_q, ce_cpu_d;

    // An increment above half range would let an enable fire on back-to-back cycles.
    if (CPU_INC > (1 << (ACC_W - 1)) || SND_INC > (1 << (ACC_W - 1))) begin : g_inc_check
        $error("pll_reset_seq: enable increment exceeds half the accumulator range");
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            sync_q   <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync_q   <= seq_io.pll_locked;
            lock_s_q <= sync_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s_q) state_d = STABLE;
            end
            STABLE: begin
                cnt_d = cnt_q + 1'b1;
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = PRE_RUN;
                    cnt_d   = '0;
                end
            end
            PRE_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == TAIL_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                cnt_d = '0;
                if (!lock_s_q) state_d = WAIT_LOCK;
            end
        endcase
    end

    // Keyed on the next state so the accumulators clear on the same edge that leaves RUN.
    assign acc_en = (state_d == PRE_RUN) || (state_d == RUN);

    always_comb begin
        {ce_cpu_d, acc_cpu_d} = {1'b0, acc_cpu_q} + (ACC_W + 1)'(CPU_INC);
        if (!acc_en) begin
            ce_cpu_d  = 1'b0;
            acc_cpu_d = '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q        <= WAIT_LOCK;
            cnt_q          <= '0;
            core_reset_n_q <= 1'b0;
            acc_cpu_q      <= '0;
            ce_cpu_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            core_reset_n_q <= (state_d == RUN);
            acc_cpu_q      <= acc_cpu_d;
            ce_cpu_q       <= ce_cpu_d;
        end
    end

`ifdef PLL_SEQ_SND_CE_EN
    logic [ACC_W-1:0] acc_snd_q, acc_snd_d;
    logic             ce_snd_q, ce_snd_d;

    always_comb begin
        {ce_snd_d, acc_snd_d} = {1'b0, acc_snd_q} + (ACC_W + 1)'(SND_INC);
        if (!acc_en) begin
            ce_snd_d  = 1'b0;
            acc_snd_d = '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            acc_snd_q <= '0;
            ce_snd_q  <= 1'b0;
        end else begin
            acc_snd_q <= acc_snd_d;
            ce_snd_q  <= ce_snd_d;
        end
    end

    assign seq_io.ce_snd = ce_snd_q;
`else
    assign seq_io.ce_snd = 1'b0;
`endif

    assign seq_io.core_reset_n = core_reset_n_q;
    assign seq_io.ce_cpu       = ce_cpu_q;
    assign seq_io.seq_state    = state_q;
endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: a short-count instance for sequencing corners and
// a default-increment instance for enable phase and rate, both tracked by a run-length model.
module tb_pll_reset_seq;
    logic clk = 1'b0;
    logic rstN;
    int   compared = 0;
    int   mismatched = 0;

    pll_reset_seq_if ifA ();
    pll_reset_seq_if ifB ();

    pll_reset_seq #(.LOCK_CYCLES(8), .RESET_TAIL(4)) dutA (
        .clk_sys (clk),
        .rst_n   (rstN),
        .seq_io  (ifA)
    );

    pll_reset_seq #(.LOCK_CYCLES(16), .RESET_TAIL(64)) dutB (
        .clk_sys (clk),
        .rst_n   (rstN),
        .seq_io  (ifB)
    );

    always #5 clk = ~clk;

    // Model: run = consecutive lock samples seen by the core (two-cycle synchroniser delay).
    int   runLen[2];
    logic syn1[2];
    logic syn2[2];
    int   lockCyc[2] = '{8, 16};
    int   tailCyc[2] = '{4, 64};

    typedef struct {
        logic       rstN;
        logic       lock;
        logic       core;
        logic [1:0] state;
    } vec_t;
    vec_t tbl[$];

    function automatic logic ceExpected(int run, int lockCycles, int inc);
        longint k;
        if (run <= lockCycles) return 1'b0;
        k = longint'(run - lockCycles);
        return ((k * inc) / 65536) != (((k - 1) * inc) / 65536);
    endfunction

    function automatic int expectedBundle(int i);
        int st;
        logic core, cpu, snd;
        if (runLen[i] == 0) st = 0;
        else if (runLen[i] <= lockCyc[i]) st = 1;
        else if (runLen[i] <= lockCyc[i] + tailCyc[i]) st = 2;
        else st = 3;
        core = (runLen[i] > lockCyc[i] + tailCyc[i]);
        cpu  = ceExpected(runLen[i], lockCyc[i], 4194);
`ifdef PLL_SEQ_SND_CE_EN
        snd  = ceExpected(runLen[i], lockCyc[i], 1222);
`else
        snd  = 1'b0;
`endif
        return (int'(core) << 4) | (st << 2) | (int'(cpu) << 1) | int'(snd);
    endfunction

    task automatic checkOutput(string name, int got, int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic checkRange(string name, int got, int lo, int hi);
        compared++;
        if (got < lo || got > hi) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic applyStimulus(logic r, logic lockA, logic lockB);
        logic lk[2];
        rstN = r;
        ifA.pll_locked = lockA;
        ifB.pll_locked = lockB;
        lk[0] = lockA;
        lk[1] = lockB;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!r) begin
                syn1[i] = 1'b0;
                syn2[i] = 1'b0;
                runLen[i] = 0;
            end else begin
                runLen[i] = syn2[i] ? runLen[i] + 1 : 0;
                syn2[i] = syn1[i];
                syn1[i] = lk[i];
            end
        end
        checkOutput("modelA", {ifA.core_reset_n, ifA.seq_state, ifA.ce_cpu, ifA.ce_snd}, expectedBundle(0));
        checkOutput("modelB", {ifB.core_reset_n, ifB.seq_state, ifB.ce_cpu, ifB.ce_snd}, expectedBundle(1));
    endtask

    initial begin
        int firstRise, earlyRise, lossPulses, segLeft;
        int preCnt, firstCpu, firstSnd, stablePulses, cpuCnt, sndCnt, backToBack;
        logic segVal, prevCpu, prevSnd, reached;

        for (int i = 0; i < 2; i++) begin
            runLen[i] = 0;
            syn1[i] = 1'b0;
            syn2[i] = 1'b0;
        end
        rstN = 1'b0;
        ifA.pll_locked = 1'b0;
        ifB.pll_locked = 1'b0;

        // Reset then steady lock: release exactly 14 edges after the first lock sample.
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0});
        for (int i = 0; i < 16; i++)
            tbl.push_back('{1'b1, 1'b1, (i >= 14), (i < 2) ? 2'd0 : (i < 10) ? 2'd1 : (i < 14) ? 2'd2 : 2'd3});
        foreach (tbl[n]) begin
            applyStimulus(tbl[n].rstN, tbl[n].lock, 1'b0);
            checkOutput($sformatf("tbl%0d_core", n), ifA.core_reset_n, tbl[n].core);
            checkOutput($sformatf("tbl%0d_state", n), ifA.seq_state, tbl[n].state);
            checkOutput($sformatf("tbl%0d_ce", n), {ifA.ce_cpu, ifA.ce_snd}, 0);
        end

        // Reset while running drops core reset on the first low edge.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("midreset_core", ifA.core_reset_n, 0);
        checkOutput("midreset_state", ifA.seq_state, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Glitch rejection: 5 high, 1 low, then high again.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        firstRise = -1;
        earlyRise = 0;
        for (int i = 0; i < 40 && firstRise < 0; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            if (ifA.core_reset_n) begin
                firstRise = i;
                if (i < 14) earlyRise++;
            end
        end
        checkOutput("glitch_release_edge", firstRise, 14);
        checkOutput("glitch_early_release", earlyRise, 0);

        // Lock loss in RUN.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("loss_e0_core", ifA.core_reset_n, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("loss_e1_core", ifA.core_reset_n, 1);
        checkOutput("loss_e1_state", ifA.seq_state, 3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("loss_e2_core", ifA.core_reset_n, 0);
        checkOutput("loss_e2_state", ifA.seq_state, 0);
        lossPulses = int'(ifA.ce_cpu);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            lossPulses += int'(ifA.ce_cpu);
        end
        checkOutput("loss_ce_cpu_pulses", lossPulses, 0);

        // Randomised lock segments and occasional resets, checked against the model.
        segLeft = 0;
        segVal = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (segLeft == 0) begin
                segLeft = $urandom_range(1, 40);
                segVal = ($urandom_range(0, 9) < 7);
            end
            segLeft--;
            applyStimulus(($urandom_range(0, 199) != 0), segVal, 1'b0);
        end

        // Default increments: first-pulse phase in PRE_RUN, then rate over 65536 RUN cycles.
        preCnt = 0;
        firstCpu = -1;
        firstSnd = -1;
        stablePulses = 0;
        sndCnt = 0;
        reached = 1'b0;
        for (int i = 0; i < 300 && !reached; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (ifB.seq_state == 2'd2) preCnt++;
            if (ifB.seq_state < 2'd2 && (ifB.ce_cpu || ifB.ce_snd)) stablePulses++;
            if (ifB.ce_cpu && firstCpu < 0) firstCpu = preCnt;
            if (ifB.ce_snd && firstSnd < 0) firstSnd = preCnt;
            sndCnt += int'(ifB.ce_snd);
            reached = ifB.core_reset_n;
        end
        checkOutput("runB_reached", reached, 1);
        checkOutput("stable_pulses", stablePulses, 0);
        checkOutput("first_ce_cpu_cycle", firstCpu, 16);
`ifdef PLL_SEQ_SND_CE_EN
        checkOutput("first_ce_snd_cycle", firstSnd, 54);
`else
        checkOutput("pre_run_ce_snd_count", sndCnt, 0);
`endif

        cpuCnt = 0;
        sndCnt = 0;
        backToBack = 0;
        prevCpu = 1'b0;
        prevSnd = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            cpuCnt += int'(ifB.ce_cpu);
            sndCnt += int'(ifB.ce_snd);
            if ((prevCpu && ifB.ce_cpu) || (prevSnd && ifB.ce_snd)) backToBack++;
            prevCpu = ifB.ce_cpu;
            prevSnd = ifB.ce_snd;
        end
        checkRange("ce_cpu_rate", cpuCnt, 4193, 4195);
`ifdef PLL_SEQ_SND_CE_EN
        checkRange("ce_snd_rate", sndCnt, 1221, 1223);
`else
        checkOutput("ce_snd_tied_low", sndCnt, 0);
`endif
        checkOutput("back_to_back", backToBack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
